sv_bus_mux_demux_arb: RTL and testbench

SV_BUS_MUX_DEMUX_ARB -- requirements
Module: sv_bus_mux_demux_arb

---
 rtl/sv_bus_mux_demux_arb_pkg.sv | 14 +
 rtl/sv_bus_mux_demux_arb_rr.sv | 30 +++
 rtl/sv_bus_mux_demux_arb.sv | 70 +++++++
 tb/tb_sv_bus_mux_demux_arb.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/sv_bus_mux_demux_arb_pkg.sv
// Shared bus types for the requester arbiter: default requester count,
// requester-id type and the adr/dat word carried on the shared bus.
package package_bus;

    localparam int ARB_N_DEF = 4;

    typedef logic [$clog2(ARB_N_DEF)-1:0] t_arb_id;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
    } t_bus;

endpackage

// File: rtl/sv_bus_mux_demux_arb_rr.sv
// Round-robin winner search: first set req bit at or after ptr+1 (mod N).
// Purely combinational; any is 0 when no request is set.
module sv_bus_mux_demux_arb_rr #(
    parameter int  N   = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [IDW-1:0] win,
    output logic           any
);

    int idx;

    always_comb begin
        win = '0;
        any = 1'b0;
        idx = 0;
        // Offsets 1..N visit every index once, ending on ptr itself.
        for (int i = 1; i <= N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) idx = idx - N;
            if (!any && req[idx[IDW-1:0]]) begin
                any = 1'b1;
                win = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/sv_bus_mux_demux_arb.sv
// Round-robin arbiter merging ARB_N requesters onto one registered shared bus
// stage; loads whenever the stage is empty or being drained this cycle.
module sv_bus_mux_demux_arb
    import package_bus::*;
#(
    parameter int  ARB_N = ARB_N_DEF,
    localparam int IDW   = $clog2(ARB_N)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ARB_N-1:0]       req_vld,
    input  logic [ARB_N-1:0][31:0] req_adr,
    input  logic [ARB_N-1:0][31:0] req_dat,
    output logic [ARB_N-1:0]       req_rdy,
    output logic                   bus_vld,
    output logic [31:0]            bus_adr,
    output logic [31:0]            bus_dat,
    input  logic                   bus_rdy,
    output logic [IDW-1:0]         bus_id
);

    t_bus           bus_q;
    logic           bus_vld_q;
    logic [IDW-1:0] bus_id_q;
    logic [IDW-1:0] ptr_q;

    logic           load_en;
    logic [IDW-1:0] win;
    logic           any;

    sv_bus_mux_demux_arb_rr #(.N(ARB_N)) u_rr (
        .req (req_vld),
        .ptr (ptr_q),
        .win (win),
        .any (any)
    );

    assign load_en = ~bus_vld_q | bus_rdy;

    // Reset gates the grant so no requester sees an acknowledge it cannot get.
    always_comb begin
        req_rdy = '0;
        if (rst_n && any && load_en) req_rdy[win] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_q     <= '0;
            bus_vld_q <= 1'b0;
            bus_id_q  <= '0;
            ptr_q     <= IDW'(ARB_N - 1);
        end else if (load_en) begin
            if (any) begin
                bus_q.adr <= req_adr[win];
                bus_q.dat <= req_dat[win];
                bus_id_q  <= win;
                ptr_q     <= win;
                bus_vld_q <= 1'b1;
            end else begin
                bus_vld_q <= 1'b0;
            end
        end
    end

    assign bus_vld = bus_vld_q;
    assign bus_adr = bus_q.adr;
    assign bus_dat = bus_q.dat;
    assign bus_id  = bus_id_q;

endmodule

// File: tb/tb_sv_bus_mux_demux_arb.sv
// Directed bench for the round-robin bus arbiter: reset, rotation,
// backpressure, sparse requests, single requester and idle drain.
module tb_sv_bus_mux_demux_arb;

    localparam int ARB_N = 4;

    logic                   clk;
    logic                   rst_n;
    logic [ARB_N-1:0]       req_vld;
    logic [ARB_N-1:0][31:0] req_adr;
    logic [ARB_N-1:0][31:0] req_dat;
    logic [ARB_N-1:0]       req_rdy;
    logic                   bus_vld;
    logic [31:0]            bus_adr;
    logic [31:0]            bus_dat;
    logic                   bus_rdy;
    logic [1:0]             bus_id;

    int n_pass  = 0;
    int n_total = 0;

    sv_bus_mux_demux_arb #(.ARB_N(ARB_N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_vld (req_vld),
        .req_adr (req_adr),
        .req_dat (req_dat),
        .req_rdy (req_rdy),
        .bus_vld (bus_vld),
        .bus_adr (bus_adr),
        .bus_dat (bus_dat),
        .bus_rdy (bus_rdy),
        .bus_id  (bus_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_id[3];
        exp_id = '{3, 1, 3};

        rst_n   = 1'b0;
        req_vld = '0;
        bus_rdy = 1'b0;
        for (int i = 0; i < ARB_N; i++) begin
            req_adr[i] = 32'hA000_0000 + 32'(i * 4);
            req_dat[i] = 32'hD000_0000 + 32'(i);
        end

        // Reset state, with requests present during reset
        repeat (2) tick();
        req_vld = 4'b1111;
        #1;
        chk("rst_bus_vld", 64'(bus_vld), 64'd0);
        chk("rst_bus_id",  64'(bus_id),  64'd0);
        chk("rst_bus_adr", 64'(bus_adr), 64'd0);
        chk("rst_bus_dat", 64'(bus_dat), 64'd0);
        chk("rst_req_rdy", 64'(req_rdy), 64'd0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("first_grant_rdy", 64'(req_rdy), 64'b0001);
        tick();
        chk("first_vld", 64'(bus_vld), 64'd1);
        chk("first_id",  64'(bus_id),  64'd0);
        chk("first_adr", 64'(bus_adr), 64'hA000_0000);
        chk("stall_rdy", 64'(req_rdy), 64'd0);

        // Rotation: 1,2,3,0 after the initial 0, one word per cycle
        bus_rdy = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("rot_vld", 64'(bus_vld), 64'd1);
            chk("rot_id",  64'(bus_id),  64'(k % 4));
            chk("rot_adr", 64'(bus_adr), 64'(32'hA000_0000 + 32'((k % 4) * 4)));
        end

        // Reset while a word is pending discards it
        bus_rdy = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstp_vld", 64'(bus_vld), 64'd0);
        chk("rstp_rdy", 64'(req_rdy), 64'd0);
        chk("rstp_adr", 64'(bus_adr), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rstp_regrant_id",  64'(bus_id),  64'd0);
        chk("rstp_regrant_vld", 64'(bus_vld), 64'd1);

        // Backpressure holding requester 1's word
        bus_rdy = 1'b1;
        tick();
        chk("bp_load_id",  64'(bus_id),  64'd1);
        chk("bp_load_adr", 64'(bus_adr), 64'hA000_0004);
        bus_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_vld", 64'(bus_vld), 64'd1);
            chk("bp_id",  64'(bus_id),  64'd1);
            chk("bp_adr", 64'(bus_adr), 64'hA000_0004);
            chk("bp_dat", 64'(bus_dat), 64'hD000_0001);
            chk("bp_rdy", 64'(req_rdy), 64'd0);
        end
        bus_rdy = 1'b1;
        #1;
        chk("bp_release_rdy", 64'(req_rdy), 64'b0100);
        tick();
        chk("bp_next_id",  64'(bus_id),  64'd2);
        chk("bp_next_adr", 64'(bus_adr), 64'hA000_0008);

        // Sparse requests from ptr=1: 3,1,3
        req_vld = 4'b0010;
        tick();
        chk("sp_setup_id", 64'(bus_id), 64'd1);
        req_vld = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("sp_id",  64'(bus_id),  64'(exp_id[k]));
            chk("sp_dat", 64'(bus_dat), 64'(32'hD000_0000 + 32'(exp_id[k])));
        end

        // Single requester streams 8 words in order
        req_vld = 4'b0100;
        for (int k = 0; k < 8; k++) begin
            req_dat[2] = 32'h2200_0000 + 32'(k);
            #1;
            chk("single_rdy", 64'(req_rdy), 64'b0100);
            tick();
            chk("single_id",  64'(bus_id),  64'd2);
            chk("single_dat", 64'(bus_dat), 64'(32'h2200_0000 + 32'(k)));
        end

        // Idle drain: bus empties, ptr stays on 2
        req_vld = '0;
        #1;
        chk("drain_rdy", 64'(req_rdy), 64'd0);
        tick();
        chk("drain_vld", 64'(bus_vld), 64'd0);
        chk("drain_id",  64'(bus_id),  64'd2);
        chk("drain_dat", 64'(bus_dat), 64'h2200_0007);
        req_vld = 4'b1111;
        bus_rdy = 1'b0;
        #1;
        chk("drain_ptr_rdy", 64'(req_rdy), 64'b1000);
        tick();
        chk("drain_next_id",  64'(bus_id),  64'd3);
        chk("drain_next_adr", 64'(bus_adr), 64'hA000_000C);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
